// File: rtl/reg_addr_decoder.sv
// Registered one-hot address decoder for the register bank ports.
// Optional build macro ADDR_DEC_TRISTATE_EN: disabled output floats instead of driving zeros.
module reg_addr_decoder #(
    parameter int ADDR_WIDTH = 4,
    parameter int OUT_WIDTH  = 2**ADDR_WIDTH,
    parameter int DEPTH      = OUT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] in,
    output logic [OUT_WIDTH-1:0]  out,
    output logic                  addr_err
);

    logic [OUT_WIDTH-1:0] w_sel;
    logic [OUT_WIDTH-1:0] r_sel;
    logic [31:0]          w_addr;
    logic                 w_hit;
    logic                 w_err;
    logic                 r_err;

    assign w_addr = 32'(in);

    // Unimplemented codes decode to no select at all, never an alias.
    always_comb begin
        w_sel = '0;
        w_hit = en && (w_addr < 32'(DEPTH));
        w_err = en && !w_hit;
        for (int k = 0; k < OUT_WIDTH; k++) begin
            w_sel[k] = w_hit && (w_addr == 32'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
            r_err <= 1'b0;
        end else begin
            r_sel <= w_sel;
            r_err <= w_err;
        end
    end

    assign addr_err = r_err;

`ifdef ADDR_DEC_TRISTATE_EN
    logic r_oe;

    // Reset drives zeros; afterwards the bus is released on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oe <= 1'b1;
        end else begin
            r_oe <= en;
        end
    end

    assign out = r_oe ? r_sel : {OUT_WIDTH{1'bz}};
`else
    assign out = r_sel;
`endif

endmodule

// File: tb/tb_reg_addr_decoder.sv
// Self-checking bench for reg_addr_decoder: directed cases plus random traffic
// against a behavioural model, on a full-depth and a 12-deep instance.
module tb_reg_addr_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] in;
    wire [15:0] out16;
    wire [15:0] out12;
    wire        err16;
    wire        err12;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_out16 = '0;
    logic [15:0] m_out12 = '0;
    logic        m_err16 = 1'b0;
    logic        m_err12 = 1'b0;

`ifdef ADDR_DEC_TRISTATE_EN
    localparam logic [15:0] IDLE = 16'hzzzz;
`else
    localparam logic [15:0] IDLE = 16'h0000;
`endif

    reg_addr_decoder #(.ADDR_WIDTH(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in),
        .out(out16), .addr_err(err16)
    );

    reg_addr_decoder #(.ADDR_WIDTH(4), .DEPTH(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in),
        .out(out12), .addr_err(err12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_out(input logic e, input int a, input int depth);
        logic [15:0] one;
        if (!e) return IDLE;
        if (a >= depth) return 16'h0000;
        one = 16'h0001;
        return one << a;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: what each output must show after the latest edge or reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out16 = '0;
            m_out12 = '0;
            m_err16 = 1'b0;
            m_err12 = 1'b0;
        end else begin
            m_out16 = exp_out(en, int'(in), 16);
            m_out12 = exp_out(en, int'(in), 12);
            m_err16 = en && (int'(in) >= 16);
            m_err12 = en && (int'(in) >= 12);
        end
    end

    always @(negedge clk) begin
        chk("cmp_out16", out16, m_out16);
        chk("cmp_out12", out12, m_out12);
        chk("cmp_err16", {15'd0, err16}, {15'd0, m_err16});
        chk("cmp_err12", {15'd0, err12}, {15'd0, m_err12});
        if (!$isunknown(out16))
            chk("onehot16", {15'd0, $countones(out16) <= 1}, 16'd1);
        if (!$isunknown(out12))
            chk("onehot12", {15'd0, $countones(out12) <= 1}, 16'd1);
    end

    task automatic step(input logic e, input logic [3:0] a);
        en = e;
        in = a;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] one;
        one   = 16'h0001;
        rst_n = 1'b0;
        en    = 1'b1;
        in    = 4'd5;
        repeat (3) @(negedge clk);
        chk("rst_out", out16, 16'h0000);
        chk("rst_err", {15'd0, err16}, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst", out16, 16'h0020);

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i));
            chk("sweep", out16, one << i);
        end

        step(1'b1, 4'd3);
        chk("dis_pre", out16, 16'h0008);
        step(1'b0, 4'd3);
        chk("dis_idle", out16, IDLE);
        chk("dis_err", {15'd0, err16}, 16'h0000);
        step(1'b1, 4'd3);
        chk("dis_post", out16, 16'h0008);

        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'd9);
            chk("hold", out16, 16'h0200);
        end

        step(1'b1, 4'd13);
        chk("oor_out", out12, 16'h0000);
        chk("oor_err", {15'd0, err12}, 16'h0001);
        chk("oor_full", out16, 16'h2000);
        step(1'b1, 4'd11);
        chk("in_rng_out", out12, 16'h0800);
        chk("in_rng_err", {15'd0, err12}, 16'h0000);

        step(1'b1, 4'd15);
        chk("stream", out16, 16'h8000);
        chk("stream_err12", {15'd0, err12}, 16'h0001);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out", out16, 16'h0000);
        chk("async_err", {15'd0, err12}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 4'd4);
        chk("first_edge", out16, 16'h0010);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 4) != 0), 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
